xfer_cmd_rx: RTL and testbench
==============================

// Module: xfer_cmd_rx
// PURPOSE
//  Parametrised serial command/data receiver for the transfer centre. Deserialises a
//  framed bit stream (sync word, command, optional length plus payload) from the control
//  link and decodes buffer-status commands. Drives the ready handshake and the
//  local-scanner command, and queues payload words in an internal FIFO for the consumer.
// PARAMETERS
//  WORD_W       8      bits per serial word (>=4)
//  SYNC_WORD    8'hA5  frame-start pattern, WORD_W bits
//  PAYLOAD_MAX  4      max payload words per data frame (1..FIFO_DEPTH)
//  FIFO_DEPTH   8      payload FIFO depth, power of two
// PORTS
//  clk           in   1                  clock
//  rst           in   1                  reset, asynchronous, active-high
//  bit_valid     in   1                  bit_in is sampled this cycle
//  bit_in        in   1                  serial data, MSB first
//  peer_ready_in in   1                  downstream ready, forwarded when following
//  ready_out     out  1                  ready toward the control link
//  scanner_cmd   out  2                  00 idle, 01 start scan, 10 flush; 1-cycle pulse
//  data_out      out  WORD_W             FIFO head word
//  data_ascii    out  1                  head word came from an ASCII frame
//  data_valid    out  1                  FIFO not empty
//  data_ready    in   1                  consumer pops head when data_valid & data_ready
//  fifo_count    out  $clog2(DEPTH)+1    current FIFO occupancy
//  err_pulse     out  1                  1-cycle pulse: bad cmd/len/ASCII word/overflow
// BEHAVIOUR
//  Reset: all outputs 0, FSM=HUNT, FIFO empty, follow=0, bit counter 0.
//  Shift reg updates only on bit_valid. Word completes on the WORD_W-th valid bit, then
//   counter wraps to 0. HUNT compares the sliding window on every valid bit.
//  FSM: HUNT -(window==SYNC_WORD)-> CMD (bit counter cleared) -(word)-> decode:
//   1: follow<=0, ready_out<=0, scanner_cmd=10 for 1 cycle -> HUNT
//   2,4: follow<=1 -> HUNT.  3: follow<=1, scanner_cmd=01 for 1 cycle -> HUNT
//   5: flush FIFO (count<=0) -> HUNT.  6: no-op -> HUNT
//   7: ascii<=0 -> LEN.  8: ascii<=1 -> LEN.  others: err_pulse -> HUNT
//  LEN: word 0 or >PAYLOAD_MAX -> err_pulse, HUNT. Else remaining<=len -> DATA.
//  DATA: each word is pushed with the ascii tag. An ASCII-frame word with MSB=1 is
//   dropped with err_pulse and still counts toward len. remaining==1 on word -> HUNT.
//  ready_out (registered): follow & peer_ready_in & (fifo_count <= DEPTH-PAYLOAD_MAX);
//   1-cycle latency from peer_ready_in. Forced 0 while the backpressure term is false.
//  FIFO: push when full and no pop -> word dropped, err_pulse. Push and pop in the same
//   cycle while full -> both accepted, count unchanged. Flush and push in the same cycle
//   -> flush wins, count=0. Pointers wrap modulo DEPTH. data_out valid the same cycle as
//   data_valid (first-word fall-through).
//  scanner_cmd/err_pulse are registered, asserted the cycle after the deciding word.
//  Reset mid-frame: immediate return to the reset state. A partial word is discarded.
// STRUCTURE
//  Package xfer_pkg: command codes (CMD_BUF50=1 ... CMD_ASCII=8), scanner_cmd encodings,
//   FSM state enum {HUNT,CMD,LEN,DATA}.
//  Sub-module xfer_sync_fifo #(W=WORD_W+1,DEPTH): FWFT, flush, count; holds {ascii,word}.
// TESTING
//  1 sync A5, cmd 03, peer_ready_in=1 -> scanner_cmd=01 for 1 cycle, ready_out=1 next cyc
//  2 A5,07,03,11,22,33 -> FIFO holds 11,22,33 ascii=0, count=3, FSM back to HUNT
//  3 A5,08,02,41,C1 -> 41 queued ascii=1, C1 dropped, one err_pulse; A5,09 -> err_pulse
//  4 fill FIFO to 8 with data_ready=0 -> ready_out=0 at count>4, 9th word err_pulse
//  5 count=8, push and pop same cycle -> count stays 8; A5,05 with push -> count=0
//  6 assert rst mid-payload (bit 5 of word 2) -> outputs 0, then A5,01 -> scanner_cmd=10

Source files
------------

// File: rtl/xfer_pkg.sv
// Shared definitions for the transfer-centre serial command receiver:
// command codes, scanner command encodings and the frame parser states.
package xfer_pkg;

  localparam int CMD_BUF50   = 1;
  localparam int CMD_BUF_OK  = 2;
  localparam int CMD_SCAN    = 3;
  localparam int CMD_BUF_LOW = 4;
  localparam int CMD_FLUSH   = 5;
  localparam int CMD_NOP     = 6;
  localparam int CMD_BIN     = 7;
  localparam int CMD_ASCII   = 8;

  typedef enum logic [1:0] {
    SCAN_IDLE  = 2'b00,
    SCAN_START = 2'b01,
    SCAN_FLUSH = 2'b10
  } scan_cmd_e;

  typedef enum logic [1:0] {
    HUNT,
    CMD,
    LEN,
    DATA
  } state_e;

endpackage

// File: rtl/xfer_sync_fifo.sv
// First-word-fall-through payload FIFO with synchronous flush and occupancy count.
// Flush overrides any push/pop in the same cycle.
module xfer_sync_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [W-1:0]  rdata_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o,
  output logic          ovf_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic          full, do_pop, do_push;

  assign valid_o = (count_q != '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & valid_o;
  // A pop frees the slot this cycle, so a push into a full FIFO is still accepted.
  assign do_push = push_i & (~full | do_pop);
  assign ovf_o   = push_i & ~do_push & ~flush_i;
  assign rdata_o = valid_o ? mem_q[rd_q] : '0;
  assign count_o = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/xfer_cmd_rx.sv
// Serial command/data receiver: hunts for the sync word, decodes buffer-status
// commands, drives ready/scanner controls and queues payload words in a FIFO.
module xfer_cmd_rx
  import xfer_pkg::*;
#(
  parameter int                WORD_W      = 8,
  parameter logic [WORD_W-1:0] SYNC_WORD   = 8'hA5,
  parameter int                PAYLOAD_MAX = 4,
  parameter int                FIFO_DEPTH  = 8,
  localparam int               CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              peer_ready_in,
  output logic              ready_out,
  output logic [1:0]        scanner_cmd,
  output logic [WORD_W-1:0] data_out,
  output logic              data_ascii,
  output logic              data_valid,
  input  logic              data_ready,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              err_pulse
);

  localparam int               BIT_W    = $clog2(WORD_W);
  localparam int               REM_W    = $clog2(PAYLOAD_MAX + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] BP_LIMIT = CNT_W'(FIFO_DEPTH - PAYLOAD_MAX);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shift_q, word;
  logic [BIT_W-1:0]  cnt_q, cnt_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic              follow_q, follow_d, ascii_q, ascii_d;
  logic              ready_q, err_q;
  scan_cmd_e         scan_q, scan_d;
  logic              word_done, len_ok, bad_word, push_req, flush, kill_ready, ovf;
  logic [WORD_W:0]   fifo_rdata;

  // The word as it stands once the current bit is shifted in.
  assign word      = {shift_q[WORD_W-2:0], bit_in};
  assign word_done = bit_valid & (cnt_q == LAST_BIT) & (state_q != HUNT);
  assign len_ok    = (word != '0) && (word <= WORD_W'(PAYLOAD_MAX));
  assign cnt_d     = (state_q == HUNT || (bit_valid && cnt_q == LAST_BIT)) ? '0
                   : cnt_q + BIT_W'(bit_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT:    if (bit_valid && word == SYNC_WORD) state_d = CMD;
      CMD:     if (word_done) state_d = (word == WORD_W'(CMD_BIN) ||
                                         word == WORD_W'(CMD_ASCII)) ? LEN : HUNT;
      LEN:     if (word_done) state_d = len_ok ? DATA : HUNT;
      DATA:    if (word_done && rem_q == REM_W'(1)) state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    follow_d   = follow_q;
    ascii_d    = ascii_q;
    rem_d      = rem_q;
    scan_d     = SCAN_IDLE;
    bad_word   = 1'b0;
    push_req   = 1'b0;
    flush      = 1'b0;
    kill_ready = 1'b0;
    if (word_done) begin
      case (state_q)
        CMD: begin
          case (word)
            WORD_W'(CMD_BUF50): begin
              follow_d   = 1'b0;
              kill_ready = 1'b1;
              scan_d     = SCAN_FLUSH;
            end
            WORD_W'(CMD_BUF_OK), WORD_W'(CMD_BUF_LOW): follow_d = 1'b1;
            WORD_W'(CMD_SCAN): begin
              follow_d = 1'b1;
              scan_d   = SCAN_START;
            end
            WORD_W'(CMD_FLUSH): flush   = 1'b1;
            WORD_W'(CMD_NOP):   ;
            WORD_W'(CMD_BIN):   ascii_d = 1'b0;
            WORD_W'(CMD_ASCII): ascii_d = 1'b1;
            default:            bad_word = 1'b1;
          endcase
        end
        LEN: begin
          if (len_ok) rem_d = REM_W'(word);
          else        bad_word = 1'b1;
        end
        DATA: begin
          rem_d = rem_q - REM_W'(1);
          // Non-7-bit characters in an ASCII frame are dropped but still consume length.
          if (ascii_q && word[WORD_W-1]) bad_word = 1'b1;
          else                           push_req = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      follow_q <= 1'b0;
      ascii_q  <= 1'b0;
      ready_q  <= 1'b0;
      scan_q   <= SCAN_IDLE;
      err_q    <= 1'b0;
    end else begin
      if (bit_valid) shift_q <= word;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      follow_q <= follow_d;
      ascii_q  <= ascii_d;
      ready_q  <= ~kill_ready & follow_q & peer_ready_in & (fifo_count <= BP_LIMIT);
      scan_q   <= scan_d;
      err_q    <= bad_word | ovf;
    end
  end

  xfer_sync_fifo #(
    .W     (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_req),
    .wdata_i ({ascii_q, word}),
    .pop_i   (data_ready),
    .flush_i (flush),
    .rdata_o (fifo_rdata),
    .valid_o (data_valid),
    .count_o (fifo_count),
    .ovf_o   (ovf)
  );

  assign data_out    = fifo_rdata[WORD_W-1:0];
  assign data_ascii  = fifo_rdata[WORD_W];
  assign ready_out   = ready_q;
  assign scanner_cmd = scan_q;
  assign err_pulse   = err_q;

endmodule

// File: tb/tb_xfer_cmd_rx.sv
// Randomised bench for xfer_cmd_rx: frames are built as word lists and a
// frame-level model (queue FIFO, follow/ascii flags) predicts every output.
module tb_xfer_cmd_rx;

  localparam int PMAX  = 4;
  localparam int DEPTH = 8;
  localparam int EV_NONE = 0, EV_CMD = 1, EV_LEN = 2, EV_PAY = 3;

  logic       clk, rst, bit_valid, bit_in, peer_ready_in, data_ready;
  logic       ready_out, data_ascii, data_valid, err_pulse;
  logic [1:0] scanner_cmd;
  logic [7:0] data_out;
  logic [3:0] fifo_count;

  xfer_cmd_rx #(
    .WORD_W      (8),
    .SYNC_WORD   (8'hA5),
    .PAYLOAD_MAX (PMAX),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bit_valid     (bit_valid),
    .bit_in        (bit_in),
    .peer_ready_in (peer_ready_in),
    .ready_out     (ready_out),
    .scanner_cmd   (scanner_cmd),
    .data_out      (data_out),
    .data_ascii    (data_ascii),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .fifo_count    (fifo_count),
    .err_pulse     (err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Model state
  logic [8:0] mq[$];
  bit         m_follow = 0;
  bit         m_ascii  = 0;
  int         dr_prob   = 0;
  bit         dr_on_pay = 0;
  int         peer_prob = 100;
  logic [7:0] pl_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_follow = 0;
    m_ascii  = 0;
  endtask

  // One clock: drive inputs, check pre-edge FIFO view, predict and check registered outputs.
  task automatic step(input logic bv, input logic b, input int ev, input logic [7:0] w);
    int         sz;
    bit         pop, push, kill, flush, ofollow, exp_rdy;
    logic [1:0] es;
    logic       ee;
    bit_valid     = bv;
    bit_in        = b;
    data_ready    = dr_on_pay ? (ev == EV_PAY) : ($urandom_range(0, 99) < dr_prob);
    peer_ready_in = ($urandom_range(0, 99) < peer_prob);
    sz = mq.size();
    chk("count", fifo_count, sz);
    chk("valid", data_valid, sz > 0);
    if (sz > 0) begin
      chk("dout", data_out, mq[0][7:0]);
      chk("dascii", data_ascii, mq[0][8]);
    end
    pop = data_ready && sz > 0;
    push = 0; kill = 0; flush = 0; es = 2'b00; ee = 1'b0;
    ofollow = m_follow;
    case (ev)
      EV_CMD: case (w)
        1: begin m_follow = 0; kill = 1; es = 2'b10; end
        2, 4: m_follow = 1;
        3: begin m_follow = 1; es = 2'b01; end
        5: flush = 1;
        6: ;
        7: m_ascii = 0;
        8: m_ascii = 1;
        default: ee = 1'b1;
      endcase
      EV_LEN: if (w == 0 || w > PMAX) ee = 1'b1;
      EV_PAY: if (m_ascii && w[7]) ee = 1'b1; else push = 1;
      default: ;
    endcase
    exp_rdy = !kill && ofollow && peer_ready_in && (sz <= DEPTH - PMAX);
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (sz < DEPTH || pop) mq.push_back({m_ascii, w});
        else ee = 1'b1;
      end
    end
    @(posedge clk); #1;
    chk("scanner_cmd", scanner_cmd, es);
    chk("err_pulse", err_pulse, ee);
    chk("ready_out", ready_out, exp_rdy);
  endtask

  task automatic send_word(input logic [7:0] w, input int ev);
    for (int i = 7; i >= 0; i--) begin
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 2)) step(1'b0, 1'($urandom_range(0, 1)), EV_NONE, 8'h00);
      step(1'b1, w[i], (i == 0) ? ev : EV_NONE, w);
    end
  endtask

  // Zero preamble keeps a stale word tail from forming a false sync window.
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len);
    send_word(8'h00, EV_NONE);
    send_word(8'hA5, EV_NONE);
    send_word(cmd, EV_CMD);
    if (cmd == 8'd7 || cmd == 8'd8) begin
      send_word(len, EV_LEN);
      if (len >= 1 && len <= PMAX)
        for (int i = 0; i < int'(len); i++) send_word(pl_q[i], EV_PAY);
    end
    step(1'b0, 1'b0, EV_NONE, 8'h00);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, ready_out, 0);
    chk({tag, "_scan"}, scanner_cmd, 0);
    chk({tag, "_dout"}, data_out, 0);
    chk({tag, "_ascii"}, data_ascii, 0);
    chk({tag, "_valid"}, data_valid, 0);
    chk({tag, "_count"}, fifo_count, 0);
    chk({tag, "_err"}, err_pulse, 0);
  endtask

  initial begin
    rst = 1'b1; bit_valid = 0; bit_in = 0; peer_ready_in = 0; data_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst0");
    rst = 1'b0;
    model_reset();

    // Scan command with peer ready: start-scan pulse, then ready follows
    peer_prob = 100; dr_prob = 0;
    send_frame(8'h03, 8'h00);
    chk("t1_ready", ready_out, 1);

    // Binary data frame
    pl_q = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h07, 8'h03);
    chk("t2_count", fifo_count, 3);
    chk("t2_head", data_out, 8'h11);

    // ASCII frame with one illegal character, then an unknown command
    pl_q = '{8'h41, 8'hC1};
    send_frame(8'h08, 8'h02);
    chk("t3_count", fifo_count, 4);
    send_frame(8'h09, 8'h00);

    // Fill to full, then overflow
    pl_q = '{8'h51, 8'h52, 8'h53, 8'h54};
    send_frame(8'h07, 8'h04);
    chk("t4_count", fifo_count, 8);
    chk("t4_ready", ready_out, 0);
    pl_q = '{8'h60};
    send_frame(8'h07, 8'h01);
    chk("t4_ovf_count", fifo_count, 8);

    // Push and pop while full, then flush
    dr_on_pay = 1;
    pl_q = '{8'h61};
    send_frame(8'h07, 8'h01);
    chk("t5_count", fifo_count, 8);
    chk("t5_head", data_out, 8'h22);
    dr_on_pay = 0;
    send_frame(8'h05, 8'h00);
    chk("t5_flush", fifo_count, 0);

    // Reset in the middle of a payload word
    send_word(8'h00, EV_NONE);
    send_word(8'hA5, EV_NONE);
    send_word(8'h07, EV_CMD);
    send_word(8'h03, EV_LEN);
    send_word(8'h11, EV_PAY);
    for (int i = 7; i >= 3; i--) step(1'b1, i[0], EV_NONE, 8'h00);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame(8'h01, 8'h00);

    // Random frames
    peer_prob = 80;
    for (int f = 0; f < 60; f++) begin
      logic [7:0] cmd, len;
      case ($urandom_range(0, 2))
        0:       dr_prob = 0;
        1:       dr_prob = 30;
        default: dr_prob = 90;
      endcase
      if ($urandom_range(0, 9) < 8) cmd = 8'($urandom_range(1, 8));
      else                          cmd = 8'($urandom_range(0, 255));
      len = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 1) * 5) : 8'($urandom_range(1, PMAX));
      pl_q.delete();
      for (int i = 0; i < PMAX; i++) pl_q.push_back(8'($urandom_range(0, 255)));
      send_frame(cmd, len);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
